key_debounce4: RTL and testbench
================================

// Module: key_debounce4
// PURPOSE
//  Debounces four raw push-button lines and presents clean, latched request lines
//  directly to the 4-to-2 encoder stage. The encoder stage consumes key_req[3:0].
//  - Synchronises asynchronous inputs to clk.
//  - Filters contact bounce with per-key stability counters.
//  - Holds each press as a request flag until the consumer acknowledges it.
// PARAMETERS
//  CNT_W       16     stability counter width
//  STABLE_CNT  50000  consecutive equal synchronised samples needed to accept a level change
//                     legal range: 1 <= STABLE_CNT <= 2**CNT_W-1
// PORTS
//  clk       in   1  single system clock; all state updates on posedge
//  rst       in   1  synchronous reset, active-high
//  key_in    in   4  raw button lines, asynchronous, active-high
//  key_ack   in   4  per-key acknowledge from the consumer; clears the matching key_req bit
//  key_lvl   out  4  debounced level of each key
//  key_req   out  4  latched press request per key; feeds the encoder inputs
//  key_any   out  1  OR of key_req
// BEHAVIOUR
//  Reset (rst=1 at a posedge)
//  - sync FFs, counters, key_lvl and key_req all go to 0; every FSM goes to IDLE; key_any=0.
//  - Reset mid-count discards the partial count and any pending request.
//  Synchroniser
//  - 2-FF chain per bit; s[i] is key_in[i] delayed 2 cycles.
//  Per-key FSM: IDLE(lvl=0) -> CHK_HI -> HELD(lvl=1) -> CHK_LO -> IDLE
//  - IDLE:   s=1 -> CHK_HI, cnt=1.
//  - CHK_HI: s=1 -> cnt++; s=0 -> IDLE, cnt=0.
//            When s=1 and cnt==STABLE_CNT-1 -> HELD, lvl=1, cnt=0.
//  - HELD / CHK_LO: mirror image of IDLE / CHK_HI, with lvl=0 on exit to IDLE.
//  - STABLE_CNT=1: a single disagreeing sample flips lvl. Go straight IDLE->HELD and HELD->IDLE;
//    the CHK states are skipped.
//  - Latency: raw edge to key_lvl edge = STABLE_CNT+2 cycles.
//  - Counter never exceeds STABLE_CNT-1, so there is no wrap.
//  Requests
//  - key_req[i] sets on the same edge key_lvl[i] rises.
//  - key_req[i] clears on the edge where key_ack[i]=1.
//  - Set and ack in the same cycle: set wins and key_req[i] stays 1.
//  - Ack while key_req[i]=0 is ignored.
//  - Release does not clear key_req.
//  - A press while key_req[i]=1 is absorbed; it does not queue.
//  - key_any is registered, so it has 1-cycle lag behind key_req.
// CONFIGURATION
//  KEY_ONEHOT_EN defined
//  - At most one key_req bit is ever 1, which guarantees valid encoder input.
//  - A new press is accepted only when key_req==0 or when it coincides with the ack of the held bit.
//  - Simultaneous new presses: the lowest index wins and the others are dropped.
//  - Dropped presses still update key_lvl.
//  KEY_ONEHOT_EN undefined
//  - key_req bits are fully independent; several may be 1 together.
// STRUCTURE
//  Package debounce_pkg
//  - NUM_KEYS=4
//  - FSM state typedef {IDLE, CHK_HI, HELD, CHK_LO} as a 2-bit localparam set.
//  Sub-module debounce_chan
//  - Contents: sync FFs, counter and FSM for one key.
//  - Ports: clk, rst, raw, lvl, rise.
//  - Instantiated 4x.
//  Top
//  - Request latch, one-hot arbitration and key_any.
// TESTING (run with STABLE_CNT=4)
//  1. rst=1 for 2 cycles with key_in=4'hF -> key_lvl=0, key_req=0 and key_any=0 throughout.
//  2. key_in[2] 0->1 held at cycle 0 -> key_lvl[2]=1 and key_req=4'b0100 at cycle 6;
//     key_any=1 at cycle 7.
//  3. key_in[1] bounces 1,0,1,0 then holds 1 -> no key_lvl change until 4 stable synced samples;
//     then key_req[1]=1 exactly once.
//  4. key_req[0]=1; pulse key_ack[0] on the cycle a fresh press of key 0 completes -> key_req[0] stays 1.
//     A lone ack one cycle later -> key_req[0]=0.
//  5. KEY_ONEHOT_EN defined; key_in=4'b1010 applied together -> key_req=4'b0010 only;
//     key_lvl=4'b1010.
//  6. Assert rst while CHK_HI count=2 on key 3 -> key_lvl[3]=0 after reset.
//     Holding key_in[3]=1 after reset -> key_lvl[3]=1 another 6 cycles later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the four-key debouncer.
// The optional KEY_ONEHOT_EN build uses lowest_one() for request arbitration.
package debounce_pkg;

    localparam int unsigned NUM_KEYS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    // Isolate the lowest set bit of a key vector
    function automatic logic [NUM_KEYS-1:0] lowest_one(input logic [NUM_KEYS-1:0] x);
        return x & (~x + NUM_KEYS'(1));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability counter and level FSM.
// rise is a combinational strobe, high in the cycle whose edge raises lvl.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STABLE_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(STABLE_CNT - 1);
    localparam logic             SINGLE = (STABLE_CNT == 1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Synchroniser, stability counter and level FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        if (SINGLE) begin
                            state <= HELD;
                            lvl   <= 1'b1;
                        end else begin
                            state <= CHK_HI;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HELD;
                        lvl   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2) begin
                        if (SINGLE) begin
                            state <= IDLE;
                            lvl   <= 1'b0;
                        end else begin
                            state <= CHK_LO;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                CHK_LO: begin
                    if (sync2) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        lvl   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    lvl   <= 1'b0;
                end
            endcase
        end
    end

    // Press accepted on the coming edge
    assign rise = sync2 && (((state == IDLE) && SINGLE) ||
                            ((state == CHK_HI) && (cnt == LAST)));

endmodule

// File: rtl/key_debounce4.sv
// Four-key debouncer with latched press requests for the 4-to-2 encoder.
// Define KEY_ONEHOT_EN to keep at most one request bit set (lowest index wins).
module key_debounce4
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STABLE_CNT = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] key_ack,
    output logic [NUM_KEYS-1:0] key_lvl,
    output logic [NUM_KEYS-1:0] key_req,
    output logic                key_any
);

    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] req_next;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .STABLE_CNT (STABLE_CNT)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (key_in[i]),
            .lvl  (key_lvl[i]),
            .rise (rise[i])
        );
    end

    // Next request vector: new presses set, acks clear, set beats ack
    always_comb begin
        req_next = key_req & ~key_ack;
`ifdef KEY_ONEHOT_EN
        if ((req_next == '0) && (rise != '0)) begin
            req_next = lowest_one(rise);
        end
`else
        req_next = req_next | rise;
`endif
    end

    // Request latch and registered any-request flag
    always_ff @(posedge clk) begin
        if (rst) begin
            key_req <= '0;
            key_any <= 1'b0;
        end else begin
            key_req <= req_next;
            key_any <= |key_req;
        end
    end

endmodule

// File: tb/tb_key_debounce4.sv
// Directed self-checking bench for key_debounce4 with STABLE_CNT=4.
module tb_key_debounce4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_ack;
    logic [3:0] key_lvl;
    logic [3:0] key_req;
    logic       key_any;

    int n_checks = 0;
    int n_fail   = 0;

    key_debounce4 #(
        .CNT_W      (16),
        .STABLE_CNT (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .key_ack (key_ack),
        .key_lvl (key_lvl),
        .key_req (key_req),
        .key_any (key_any)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Two reset cycles, then release with the given key pattern applied ("cycle 0")
    task automatic reset_then(input logic [3:0] pattern);
        rst     = 1'b1;
        key_in  = 4'h0;
        key_ack = 4'h0;
        step(2);
        rst    = 1'b0;
        key_in = pattern;
    endtask

    int rises;
    logic prev;

    initial begin
        rst     = 1'b1;
        key_in  = 4'hF;
        key_ack = 4'h0;

        // 1. reset holds everything low even with all keys pressed
        for (int c = 0; c < 2; c++) begin
            step(1);
            check("rst_lvl", key_lvl, 4'h0);
            check("rst_req", key_req, 4'h0);
            check("rst_any", {3'b0, key_any}, 4'h0);
        end

        // 2. single press of key 2: level/request after 6 edges, any one later
        reset_then(4'b0100);
        step(5);
        check("k2_lvl_c5", key_lvl, 4'b0000);
        check("k2_req_c5", key_req, 4'b0000);
        step(1);
        check("k2_lvl_c6", key_lvl, 4'b0100);
        check("k2_req_c6", key_req, 4'b0100);
        check("k2_any_c6", {3'b0, key_any}, 4'h0);
        step(1);
        check("k2_any_c7", {3'b0, key_any}, 4'h1);

        // 3. bouncing key 1: 1,0,1,0 then steady 1 from cycle 4
        reset_then(4'b0010);
        step(1); key_in = 4'b0000;
        step(1); key_in = 4'b0010;
        step(1); key_in = 4'b0000;
        step(1); key_in = 4'b0010;
        step(5);
        check("k1_lvl_c9", key_lvl, 4'b0000);
        step(1);
        check("k1_lvl_c10", key_lvl, 4'b0010);
        check("k1_req_c10", key_req, 4'b0010);
        rises = 1;
        prev  = key_req[1];
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (key_req[1] && !prev) rises++;
            prev = key_req[1];
        end
        check("k1_req_once", 4'(rises), 4'd1);

        // 4. ack coinciding with a fresh press: set wins; a lone ack clears
        reset_then(4'b0001);
        step(6);
        check("k0_req_c6", key_req, 4'b0001);
        key_in = 4'b0000;
        step(6);
        check("k0_lvl_rel", key_lvl, 4'b0000);
        check("k0_req_rel", key_req, 4'b0001);
        key_in = 4'b0001;
        step(5);
        key_ack = 4'b0001;
        step(1);
        check("k0_lvl_re", key_lvl, 4'b0001);
        check("k0_req_setwin", key_req, 4'b0001);
        step(1);
        key_ack = 4'b0000;
        check("k0_req_ack", key_req, 4'b0000);
        step(1);
        check("k0_any_lag", {3'b0, key_any}, 4'h0);
        key_ack = 4'b0001;
        step(1);
        key_ack = 4'b0000;
        check("k0_ack_idle", key_req, 4'b0000);

        // 5. simultaneous presses of keys 1 and 3
        reset_then(4'b1010);
        step(6);
        check("pair_lvl", key_lvl, 4'b1010);
`ifdef KEY_ONEHOT_EN
        check("pair_req", key_req, 4'b0010);
`else
        check("pair_req", key_req, 4'b1010);
`endif

        // 6. reset in the middle of key 3's count
        reset_then(4'b1000);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("k3_lvl_rst", key_lvl, 4'b0000);
        check("k3_req_rst", key_req, 4'b0000);
        step(5);
        check("k3_lvl_c5", key_lvl, 4'b0000);
        step(1);
        check("k3_lvl_c6", key_lvl, 4'b1000);
        check("k3_req_c6", key_req, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
